// File: rtl/fine_track_seq.sv
// Fine-tracking loop sequencer: aux osc warm-up, coarse-to-fine gear shift,
// lock declare/monitor, manual code override. Ports: ref_clk/rst, cfg in, tracker if, osc out.
module fine_track_seq #(
    parameter int AUX_SETTLE_CYCLES = 64,
    parameter int UNLOCK_RUN        = 4,
    parameter int CODE_W            = 13
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              manual_mode,
    input  logic [CODE_W-1:0] manual_code,
    input  logic [3:0]        step_init,
    input  logic [4:0]        avg_window_cfg,
    input  logic [3:0]        lock_thresh,
    input  logic              dec_valid,
    input  logic              dec_up,
    input  logic [CODE_W-1:0] track_code,
    output logic              aux_osc_en,
    output logic              fftl_en,
    output logic [3:0]        step_size,
    output logic [4:0]        avg_window_select,
    output logic [CODE_W-1:0] osc_code,
    output logic              locked,
    output logic [2:0]        state
);

    localparam int SW = $clog2(AUX_SETTLE_CYCLES + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(AUX_SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(UNLOCK_RUN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MANUAL   = 3'd1,
        AUX_WARM = 3'd2,
        ACQ      = 3'd3,
        TRACK    = 3'd4,
        LOCKED   = 3'd5
    } st_t;

    st_t               st_q, st_d;
    logic              aux_d, fftl_d, lock_d;
    logic [3:0]        step_d;
    logic [4:0]        win_d;
    logic [CODE_W-1:0] code_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [3:0]        rev_q, rev_d;
    logic [RW-1:0]     run_q, run_d;
    logic              last_q, last_d;
    logic              have_q, have_d;

    logic       rev;
    logic [3:0] step_min;
    logic [3:0] thr;
    logic [3:0] rev_inc;
    logic [RW-1:0] run_inc;

    assign rev      = dec_valid & have_q & (dec_up != last_q);
    assign step_min = (step_init == 4'd0) ? 4'd1 : step_init;
    assign thr      = (lock_thresh == 4'd0) ? 4'd1 : lock_thresh;
    assign rev_inc  = (rev_q == 4'hF) ? 4'hF : rev_q + 4'd1;
    assign run_inc  = run_q + RW'(1);
    assign state    = st_q;

    always_comb begin
        st_d     = st_q;
        aux_d    = aux_osc_en;
        fftl_d   = fftl_en;
        lock_d   = locked;
        step_d   = step_size;
        win_d    = avg_window_select;
        code_d   = osc_code;
        settle_d = settle_q;
        rev_d    = rev_q;
        run_d    = run_q;
        last_d   = last_q;
        have_d   = have_q;
        // Dropping start wins over everything, including a pending decision.
        if (st_q != IDLE && !start) begin
            st_d   = IDLE;
            aux_d  = 1'b0;
            fftl_d = 1'b0;
            lock_d = 1'b0;
            rev_d  = '0;
            run_d  = '0;
            have_d = 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (start && manual_mode) begin
                        st_d = MANUAL;
                    end else if (start) begin
                        st_d     = AUX_WARM;
                        aux_d    = 1'b1;
                        settle_d = SETTLE_LD;
                    end
                end
                MANUAL: begin
                    code_d = manual_code;
                    fftl_d = 1'b0;
                    aux_d  = 1'b0;
                    if (!manual_mode) begin
                        st_d     = AUX_WARM;
                        aux_d    = 1'b1;
                        settle_d = SETTLE_LD;
                    end
                end
                AUX_WARM: begin
                    if (manual_mode) begin
                        st_d  = MANUAL;
                        aux_d = 1'b0;
                    end else if (settle_q == '0) begin
                        st_d   = ACQ;
                        fftl_d = 1'b1;
                        step_d = step_min;
                        win_d  = avg_window_cfg;
                        have_d = 1'b0;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                ACQ, TRACK, LOCKED: begin
                    code_d = track_code;
                    if (manual_mode) begin
                        st_d   = MANUAL;
                        fftl_d = 1'b0;
                        aux_d  = 1'b0;
                        lock_d = 1'b0;
                        rev_d  = '0;
                        run_d  = '0;
                        have_d = 1'b0;
                    end else if (dec_valid) begin
                        last_d = dec_up;
                        have_d = 1'b1;
                        if (st_q == ACQ) begin
                            if (rev && step_size == 4'd1) begin
                                st_d  = TRACK;
                                rev_d = '0;
                            end else if (rev) begin
                                step_d = step_size >> 1;
                            end
                        end else if (st_q == TRACK) begin
                            step_d = 4'd1;
                            if (rev) begin
                                rev_d = rev_inc;
                                if (rev_inc >= thr) begin
                                    st_d   = LOCKED;
                                    lock_d = 1'b1;
                                    run_d  = '0;
                                end
                            end else begin
                                rev_d = '0;
                            end
                        end else begin
                            if (rev) begin
                                run_d = '0;
                            end else if (run_inc == RUN_MAX) begin
                                st_d   = TRACK;
                                lock_d = 1'b0;
                                rev_d  = '0;
                                run_d  = '0;
                            end else begin
                                run_d = run_inc;
                            end
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            st_q              <= IDLE;
            aux_osc_en        <= 1'b0;
            fftl_en           <= 1'b0;
            locked            <= 1'b0;
            step_size         <= '0;
            avg_window_select <= '0;
            osc_code          <= '0;
            settle_q          <= '0;
            rev_q             <= '0;
            run_q             <= '0;
            last_q            <= 1'b0;
            have_q            <= 1'b0;
        end else begin
            st_q              <= st_d;
            aux_osc_en        <= aux_d;
            fftl_en           <= fftl_d;
            locked            <= lock_d;
            step_size         <= step_d;
            avg_window_select <= win_d;
            osc_code          <= code_d;
            settle_q          <= settle_d;
            rev_q             <= rev_d;
            run_q             <= run_d;
            last_q            <= last_d;
            have_q            <= have_d;
        end
    end

endmodule
